// File: rtl/aha_reset_req_pkg.sv
// Shared types and constants for the reset-request aggregator.
// Optional pending-request storage is enabled by defining AHA_RST_REQ_PENDING_EN.
package aha_reset_req_pkg;

   // Width of the reset-cause vector and the bit position of each source
   localparam int CAUSE_W      = 4;
   localparam int CAUSE_CPU    = 0;
   localparam int CAUSE_WDOG   = 1;
   localparam int CAUSE_LOCKUP = 2;
   localparam int CAUSE_SW     = 3;

   typedef logic [CAUSE_W-1:0] cause_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   // 8-bit increment that sticks at all-ones
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/aha_reset_req_lockup_filter.sv
// LOCKUP persistence filter: only a LOCKUP held for LOCKUP_DELAY consecutive
// cycles produces a reset trigger. The count is cleared whenever LOCKUP drops
// and whenever the parent starts a new pulse, so one lockup episode cannot
// retrigger straight after its own pulse.
module aha_reset_req_lockup_filter
   import aha_reset_req_pkg::*;
#(
   parameter int LOCKUP_DELAY = 1024
) (
   input  logic MASTER_CLK,
   input  logic MASTER_RESET,
   input  logic lockup,
   input  logic lockup_reset_en,
   input  logic cnt_clr,
   output logic lock_trig
);

   localparam logic [15:0] DELAY16 = 16'(LOCKUP_DELAY);
   localparam logic [16:0] DELAY17 = 17'(LOCKUP_DELAY);

   logic [15:0] cnt_reg;
   logic [15:0] cnt_next;
   logic [16:0] cnt_plus1;

   // Next count: clear on LOCKUP low or pulse start, else saturating increment
   always_comb begin
      cnt_next  = cnt_reg;
      cnt_plus1 = {1'b0, cnt_reg} + 17'd1;
      if (cnt_clr || !lockup) begin
         cnt_next = '0;
      end else if (cnt_reg < DELAY16) begin
         cnt_next = cnt_reg + 16'd1;
      end
   end

   // Persistence counter register
   always_ff @(posedge MASTER_CLK) begin
      if (MASTER_RESET) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   // The current cycle counts, so the trigger fires on the DELAY-th high cycle
   assign lock_trig = lockup_reset_en & lockup & (cnt_plus1 >= DELAY17);

endmodule

// File: rtl/aha_reset_req_ctrl.sv
// Reset-request aggregator in front of the platform controller SYSRESETREQ.
// Merges CPU, watchdog, persistent-lockup and software requests, stretches
// each accepted request to PULSE_CYCLES, then holds off HOLDOFF_CYCLES.
// Define AHA_RST_REQ_PENDING_EN to remember requests that arrive while busy
// and replay them directly after the hold-off window.
module aha_reset_req_ctrl
   import aha_reset_req_pkg::*;
#(
   parameter int PULSE_CYCLES   = 16,
   parameter int HOLDOFF_CYCLES = 32,
   parameter int LOCKUP_DELAY   = 1024
) (
   input  logic         MASTER_CLK,
   input  logic         MASTER_RESET,
   input  logic         SYSRESETREQ_IN,
   input  logic         WDOG_RESET_REQ,
   input  logic         LOCKUP,
   input  logic         LOCKUP_RESET_EN,
   input  logic         SW_RESET_REQ,
   input  logic         CAUSE_CLR,
   output logic         SYSRESETREQ_OUT,
   output logic [3:0]   RESET_CAUSE,
   output logic [7:0]   RESET_COUNT,
   output logic         BUSY
);

   localparam logic [7:0] PULSE_LOAD   = 8'(PULSE_CYCLES - 1);
   localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_CYCLES - 1);

   state_t      state_reg;
   state_t      state_next;
   logic [7:0]  cnt_reg;
   logic [7:0]  cnt_next;
   logic        out_reg;
   logic        out_next;
   logic        busy_reg;
   logic        busy_next;
   cause_t      cause_reg;
   cause_t      cause_next;
   logic [7:0]  count_reg;
   logic [7:0]  count_next;

   logic        lock_trig;
   cause_t      src_vec;
   logic        trig;
   cause_t      capture_vec;
   logic        enter_assert;

   aha_reset_req_lockup_filter #(
      .LOCKUP_DELAY (LOCKUP_DELAY)
   ) u_lockup_filter (
      .MASTER_CLK      (MASTER_CLK),
      .MASTER_RESET    (MASTER_RESET),
      .lockup          (LOCKUP),
      .lockup_reset_en (LOCKUP_RESET_EN),
      .cnt_clr         (enter_assert),
      .lock_trig       (lock_trig)
   );

   // Per-source request vector for this cycle, laid out as the cause bits
   always_comb begin
      src_vec               = '0;
      src_vec[CAUSE_CPU]    = SYSRESETREQ_IN;
      src_vec[CAUSE_WDOG]   = WDOG_RESET_REQ;
      src_vec[CAUSE_LOCKUP] = lock_trig;
      src_vec[CAUSE_SW]     = SW_RESET_REQ;
   end

   assign trig = |src_vec;

`ifdef AHA_RST_REQ_PENDING_EN
   logic   pend_flag_reg;
   logic   pend_flag_next;
   cause_t pend_vec_reg;
   cause_t pend_vec_next;

   // Collect requests seen while busy; consumed when the replay pulse starts
   always_comb begin
      pend_flag_next = pend_flag_reg;
      pend_vec_next  = pend_vec_reg;
      if (enter_assert) begin
         pend_flag_next = 1'b0;
         pend_vec_next  = '0;
      end else if ((state_reg != IDLE) && trig) begin
         pend_flag_next = 1'b1;
         pend_vec_next  = pend_vec_reg | src_vec;
      end
   end

   // Pending storage registers
   always_ff @(posedge MASTER_CLK) begin
      if (MASTER_RESET) begin
         pend_flag_reg <= 1'b0;
         pend_vec_reg  <= '0;
      end else begin
         pend_flag_reg <= pend_flag_next;
         pend_vec_reg  <= pend_vec_next;
      end
   end
`endif

   // FSM next state, window counter and cause/count capture on pulse start
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      capture_vec  = '0;
      enter_assert = 1'b0;
      case (state_reg)
         IDLE: begin
            if (trig) begin
               state_next   = ASSERT;
               cnt_next     = PULSE_LOAD;
               capture_vec  = src_vec;
               enter_assert = 1'b1;
            end
         end
         ASSERT: begin
            if (cnt_reg == 8'd0) begin
               state_next = HOLDOFF;
               cnt_next   = HOLDOFF_LOAD;
            end else begin
               cnt_next = cnt_reg - 8'd1;
            end
         end
         HOLDOFF: begin
            if (cnt_reg == 8'd0) begin
`ifdef AHA_RST_REQ_PENDING_EN
               // A request collected during the window (or arriving now)
               // restarts the pulse immediately, without an IDLE cycle
               if (pend_flag_reg || trig) begin
                  state_next   = ASSERT;
                  cnt_next     = PULSE_LOAD;
                  capture_vec  = pend_vec_reg | src_vec;
                  enter_assert = 1'b1;
               end else begin
                  state_next = IDLE;
               end
`else
               state_next = IDLE;
`endif
            end else begin
               cnt_next = cnt_reg - 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Registered outputs derived from where the FSM will be next cycle
   always_comb begin
      out_next   = (state_next == ASSERT);
      busy_next  = (state_next != IDLE);
      // A clear in the same cycle as a capture leaves only the new causes
      cause_next = (CAUSE_CLR ? cause_t'(0) : cause_reg) | capture_vec;
      count_next = enter_assert ? sat_inc8(count_reg) : count_reg;
   end

   // State and output registers
   always_ff @(posedge MASTER_CLK) begin
      if (MASTER_RESET) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         out_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         cause_reg <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         out_reg   <= out_next;
         busy_reg  <= busy_next;
         cause_reg <= cause_next;
         count_reg <= count_next;
      end
   end

   assign SYSRESETREQ_OUT = out_reg;
   assign BUSY            = busy_reg;
   assign RESET_CAUSE     = cause_reg;
   assign RESET_COUNT     = count_reg;

endmodule

// File: tb/tb_aha_reset_req_ctrl.sv
// Directed testbench for aha_reset_req_ctrl with a time-window reference model.
// Honours AHA_RST_REQ_PENDING_EN the same way as the design.
module tb_aha_reset_req_ctrl;

   localparam int P  = 16;
   localparam int H  = 32;
   localparam int LD = 8;
`ifdef AHA_RST_REQ_PENDING_EN
   localparam bit PEND = 1'b1;
`else
   localparam bit PEND = 1'b0;
`endif

   logic       MASTER_CLK = 1'b0;
   logic       MASTER_RESET;
   logic       SYSRESETREQ_IN;
   logic       WDOG_RESET_REQ;
   logic       LOCKUP;
   logic       LOCKUP_RESET_EN;
   logic       SW_RESET_REQ;
   logic       CAUSE_CLR;
   logic       SYSRESETREQ_OUT;
   logic [3:0] RESET_CAUSE;
   logic [7:0] RESET_COUNT;
   logic       BUSY;

   int n_assert = 0;
   int n_fail   = 0;

   aha_reset_req_ctrl #(
      .PULSE_CYCLES   (P),
      .HOLDOFF_CYCLES (H),
      .LOCKUP_DELAY   (LD)
   ) dut (
      .MASTER_CLK      (MASTER_CLK),
      .MASTER_RESET    (MASTER_RESET),
      .SYSRESETREQ_IN  (SYSRESETREQ_IN),
      .WDOG_RESET_REQ  (WDOG_RESET_REQ),
      .LOCKUP          (LOCKUP),
      .LOCKUP_RESET_EN (LOCKUP_RESET_EN),
      .SW_RESET_REQ    (SW_RESET_REQ),
      .CAUSE_CLR       (CAUSE_CLR),
      .SYSRESETREQ_OUT (SYSRESETREQ_OUT),
      .RESET_CAUSE     (RESET_CAUSE),
      .RESET_COUNT     (RESET_COUNT),
      .BUSY            (BUSY)
   );

   always #5 MASTER_CLK = ~MASTER_CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A pulse is described only by its start cycle: [start, start+P) is the
   // pulse, [start+P, start+P+H) the hold-off, everything later is idle.
   int         cyc = 0;
   bit         started = 0;
   int         start = 0;
   int         run = 0;
   logic [3:0] m_cause = '0;
   int         m_count = 0;
   bit         pflag = 0;
   logic [3:0] pvec = '0;
   bit         model_valid = 0;
   logic       exp_out, exp_busy;
   logic [3:0] exp_cause;
   logic [7:0] exp_count;

   function automatic int phase(input int t);
      if (!started || t >= start + P + H) return 0;
      if (t < start + P) return 1;
      return 2;
   endfunction

   task automatic model_step();
      int         ph;
      bit         lt, fire;
      logic [3:0] src, cap, newc;
      if (MASTER_RESET) begin
         started = 0; run = 0; m_cause = '0; m_count = 0; pflag = 0; pvec = '0;
      end else begin
         ph   = phase(cyc);
         lt   = LOCKUP_RESET_EN && LOCKUP && (run + 1 >= LD);
         src  = {SW_RESET_REQ, lt, WDOG_RESET_REQ, SYSRESETREQ_IN};
         newc = CAUSE_CLR ? 4'b0000 : m_cause;
         fire = 0;
         cap  = '0;
         if (ph == 0 && src != 0) begin
            fire = 1; cap = src;
         end else if (PEND && ph != 0) begin
            if (src != 0) begin pflag = 1; pvec = pvec | src; end
            if (ph == 2 && cyc == start + P + H - 1 && pflag) begin
               fire = 1; cap = pvec; pflag = 0; pvec = '0;
            end
         end
         if (fire) begin
            started = 1; start = cyc + 1;
            m_count = (m_count < 255) ? m_count + 1 : 255;
         end
         m_cause = newc | cap;
         run = fire ? 0 : (LOCKUP ? run + 1 : 0);
      end
      cyc       = cyc + 1;
      exp_out   = (phase(cyc) == 1);
      exp_busy  = (phase(cyc) != 0);
      exp_cause = m_cause;
      exp_count = 8'(m_count);
   endtask

   initial begin
      forever begin
         @(posedge MASTER_CLK);
         model_step();
         model_valid = 1;
      end
   end

   // Cycle-by-cycle comparison against the model, just after each edge
   initial begin
      forever begin
         @(posedge MASTER_CLK);
         #1;
         if (model_valid) begin
            chk("m_out",   32'(SYSRESETREQ_OUT), 32'(exp_out));
            chk("m_busy",  32'(BUSY),            32'(exp_busy));
            chk("m_cause", 32'(RESET_CAUSE),     32'(exp_cause));
            chk("m_count", 32'(RESET_COUNT),     32'(exp_count));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(negedge MASTER_CLK);
   endtask

   task automatic do_reset();
      SYSRESETREQ_IN = 0; WDOG_RESET_REQ = 0; LOCKUP = 0; SW_RESET_REQ = 0; CAUSE_CLR = 0;
      MASTER_RESET = 1;
      step(2);
      MASTER_RESET = 0;
      step(1);
   endtask

   initial begin
      MASTER_RESET = 1; SYSRESETREQ_IN = 0; WDOG_RESET_REQ = 0; LOCKUP = 0;
      LOCKUP_RESET_EN = 0; SW_RESET_REQ = 0; CAUSE_CLR = 0;
      step(3);
      chk("rst_out",   32'(SYSRESETREQ_OUT), 32'd0);
      chk("rst_cause", 32'(RESET_CAUSE),     32'd0);
      chk("rst_count", 32'(RESET_COUNT),     32'd0);
      chk("rst_busy",  32'(BUSY),            32'd0);
      MASTER_RESET = 0;
      step(7);

      // Software pulse: out for 16 cycles, busy for 48, idle on the 49th
      $display("test sw_pulse");
      SW_RESET_REQ = 1; step(1); SW_RESET_REQ = 0;
      chk("sw_out_first", 32'(SYSRESETREQ_OUT), 32'd1);
      step(15);
      chk("sw_out_last",  32'(SYSRESETREQ_OUT), 32'd1);
      step(1);
      chk("sw_out_end",   32'(SYSRESETREQ_OUT), 32'd0);
      step(31);
      chk("sw_busy_last", 32'(BUSY), 32'd1);
      step(1);
      chk("sw_busy_end",  32'(BUSY), 32'd0);
      chk("sw_cause",     32'(RESET_CAUSE), 32'h8);
      chk("sw_count",     32'(RESET_COUNT), 32'd1);

      // CPU and watchdog together, held for 100 cycles
      $display("test cpu_wdog_level");
      do_reset();
      SYSRESETREQ_IN = 1; WDOG_RESET_REQ = 1;
      step(1);
      chk("lvl_out_first", 32'(SYSRESETREQ_OUT), 32'd1);
      chk("lvl_cause",     32'(RESET_CAUSE), 32'h3);
      step(48);
      if (!PEND) chk("lvl_gap", 32'(SYSRESETREQ_OUT), 32'd0);
      step(1);
      chk("lvl_second", 32'(SYSRESETREQ_OUT), 32'd1);
      chk("lvl_count",  32'(RESET_COUNT), 32'd2);
      step(50);
      SYSRESETREQ_IN = 0; WDOG_RESET_REQ = 0;
      step(110);

      // Lockup persistence, enabled
      $display("test lockup_en");
      do_reset();
      LOCKUP_RESET_EN = 1;
      LOCKUP = 1; step(7); LOCKUP = 0; step(1); LOCKUP = 1; step(7);
      chk("lk_before", 32'(SYSRESETREQ_OUT), 32'd0);
      step(1); LOCKUP = 0;
      chk("lk_out",   32'(SYSRESETREQ_OUT), 32'd1);
      chk("lk_cause", 32'(RESET_CAUSE), 32'h4);
      step(60);
      chk("lk_count", 32'(RESET_COUNT), 32'd1);

      // Lockup persistence, disabled
      $display("test lockup_dis");
      do_reset();
      LOCKUP_RESET_EN = 0;
      LOCKUP = 1; step(7); LOCKUP = 0; step(1); LOCKUP = 1; step(8); LOCKUP = 0;
      chk("lkd_out",  32'(SYSRESETREQ_OUT), 32'd0);
      chk("lkd_busy", 32'(BUSY), 32'd0);
      step(5);

      // Reset in the middle of a pulse
      $display("test reset_mid_pulse");
      do_reset();
      SW_RESET_REQ = 1; step(1); SW_RESET_REQ = 0;
      step(4);
      MASTER_RESET = 1; step(1);
      chk("mr_out",   32'(SYSRESETREQ_OUT), 32'd0);
      chk("mr_cause", 32'(RESET_CAUSE), 32'd0);
      chk("mr_count", 32'(RESET_COUNT), 32'd0);
      chk("mr_busy",  32'(BUSY), 32'd0);
      MASTER_RESET = 0;
      step(3);

      // Clear together with a watchdog capture
      $display("test clr_with_capture");
      do_reset();
      SW_RESET_REQ = 1; step(1); SW_RESET_REQ = 0;
      step(60);
      chk("clr_prior", 32'(RESET_CAUSE), 32'h8);
      WDOG_RESET_REQ = 1; CAUSE_CLR = 1; step(1); WDOG_RESET_REQ = 0; CAUSE_CLR = 0;
      chk("clr_cause", 32'(RESET_CAUSE), 32'h2);
      chk("clr_count", 32'(RESET_COUNT), 32'd2);
      step(60);
      CAUSE_CLR = 1; step(1); CAUSE_CLR = 0;
      chk("clr_only", 32'(RESET_CAUSE), 32'h0);
      chk("clr_keep_count", 32'(RESET_COUNT), 32'd2);

      // Software request during hold-off
      $display("test sw_in_holdoff");
      do_reset();
      SW_RESET_REQ = 1; step(1); SW_RESET_REQ = 0;
      step(29);
      SW_RESET_REQ = 1; step(1); SW_RESET_REQ = 0;
      step(17);
      chk("ho_last", 32'(SYSRESETREQ_OUT), 32'd0);
      step(1);
      if (PEND) begin
         chk("ho_replay_out",   32'(SYSRESETREQ_OUT), 32'd1);
         chk("ho_replay_cause", 32'(RESET_CAUSE[3]), 32'd1);
         chk("ho_replay_count", 32'(RESET_COUNT), 32'd2);
      end else begin
         chk("ho_lost_out",   32'(SYSRESETREQ_OUT), 32'd0);
         chk("ho_lost_busy",  32'(BUSY), 32'd0);
         chk("ho_lost_count", 32'(RESET_COUNT), 32'd1);
      end
      step(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
